// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential multiplier controller.
package mult_seq_pkg;

  localparam int MULT_SEQ_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW  = 3'd1,
    S_HIGH = 3'd2,
    S_MID  = 3'd3,
    S_COMB = 3'd4,
    S_DONE = 3'd5
  } mult_state_t;

endpackage

// File: rtl/karatsuba_uint_mult.sv
// Unsigned N x N -> 2N combinational multiplier, the single arithmetic
// multiplier shared by all passes of mult_seq_ctrl.
module karatsuba_uint_mult #(
  parameter int N = 8
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] z
);

  assign z = (2*N)'(x) * (2*N)'(y);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential W x W unsigned multiplier built from three W/2-bit passes of one
// shared multiplier (Karatsuba). Optional macro MULT_SEQ_ZERO_SKIP_EN skips
// the passes when either operand is zero.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a request
// LOW    | register al*bl
// HIGH   | register ah*bh
// MID    | register sa*sb (low bits of the half sums)
// COMB   | combine partial products into p
// DONE   | out_valid high, wait for out_ready
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int W = MULT_SEQ_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int H = W / 2;

  mult_state_t state;

  logic [W-1:0] a_r, b_r;
  logic [W-1:0] lo_r, hi_r, mm_r;

  logic [H-1:0] al, ah, bl, bh;
  logic [H:0]   sum_a, sum_b;
  logic [H-1:0] sa, sb;
  logic         ca, cb;

  logic [H-1:0] mul_x, mul_y;
  logic [W-1:0] mul_z;

  logic [W+1:0]   cross_w, mid_w, mid_sub;
  logic [2*W-1:0] p_next;

  assign al = a_r[H-1:0];
  assign ah = a_r[W-1:H];
  assign bl = b_r[H-1:0];
  assign bh = b_r[W-1:H];

  assign sum_a = {1'b0, ah} + {1'b0, al};
  assign sum_b = {1'b0, bh} + {1'b0, bl};
  assign sa    = sum_a[H-1:0];
  assign sb    = sum_b[H-1:0];
  assign ca    = sum_a[H];
  assign cb    = sum_b[H];

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state)
      S_LOW:  begin mul_x = al; mul_y = bl; end
      S_HIGH: begin mul_x = ah; mul_y = bh; end
      S_MID:  begin mul_x = sa; mul_y = sb; end
      default: ;
    endcase
  end

  karatsuba_uint_mult #(.N(H)) u_mult (
    .x (mul_x),
    .y (mul_y),
    .z (mul_z)
  );

  // Restore the full (ah+al)*(bh+bl) from the truncated sums and their carries.
  assign cross_w = (W+2)'(ca ? sb : '0) + (W+2)'(cb ? sa : '0);
  assign mid_w   = (W+2)'(mm_r) + (cross_w << H) + ((W+2)'(ca & cb) << W);
  assign mid_sub = mid_w - (W+2)'(hi_r) - (W+2)'(lo_r);
  assign p_next  = {hi_r, {W{1'b0}}} + ((2*W)'(mid_sub) << H) + (2*W)'(lo_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
      mm_r      <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            if (a == '0 || b == '0) begin
              p         <= '0;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_LOW;
            end
`else
            state <= S_LOW;
`endif
          end
        end
        S_LOW: begin
          lo_r  <= mul_z;
          state <= S_HIGH;
        end
        S_HIGH: begin
          hi_r  <= mul_z;
          state <= S_MID;
        end
        S_MID: begin
          mm_r  <= mul_z;
          state <= S_COMB;
        end
        S_COMB: begin
          p         <= p_next;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: directed corner cases plus randomized requests
// against a plain a*b reference, with a handshake accounting monitor.
`timescale 1ns/1ps
module tb_mult_seq_ctrl;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int total = 0;
  int bad   = 0;

  int pending  = 0;
  int dup_cnt  = 0;
  int res_cnt  = 0;
  int ops_done = 0;
  logic [2*W-1:0] last_p;

  mult_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Every accepted request must yield exactly one result handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 0;
    end else if (in_valid && in_ready) begin
      pending <= pending + 1;
    end else if (out_valid && out_ready) begin
      res_cnt <= res_cnt + 1;
      if (pending == 0) dup_cnt <= dup_cnt + 1;
      else              pending <= pending - 1;
    end
  end

  // Latency counts rising edges with the accept edge as edge 1.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int hold, input string tag);
    logic [2*W-1:0] exp_p;
    int exp_lat;
    int lat;
    exp_p   = (2*W)'(av) * (2*W)'(bv);
    exp_lat = 5;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    if (av == '0 || bv == '0) exp_lat = 1;
`endif
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = (hold == 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'($urandom_range(0, 1));
    a = W'($urandom);
    b = W'($urandom);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_p"}, 64'(p), 64'(exp_p));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_p"}, 64'(p), 64'(exp_p));
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      a = W'($urandom);
      b = W'($urandom);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_p_kept"}, 64'(p), 64'(exp_p));
    last_p = p;
    ops_done++;
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_p", 64'(p), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h5678, 0, "basic");
    check("basic_const", 64'(last_p), 64'h0626_0060);
    run_op(16'hFFFF, 16'hFFFF, 0, "max");
    check("max_const", 64'(last_p), 64'hFFFE_0001);
    run_op(16'hABCD, 16'h1357, 10, "hold");

    // Abort an operation while it is in the MID pass.
    in_valid = 1'b1;
    a = 16'h7777;
    b = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy", 64'(busy), 64'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_p", 64'(p), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy_clr", 64'(busy), 64'd0);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run_op(16'd3, 16'd5, 0, "post_rst");
    check("post_rst_const", 64'(last_p), 64'd15);

    run_op(16'h0000, 16'h00FF, 0, "zero_a");
    run_op(16'h00FF, 16'h0000, 2, "zero_b");

    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = '1;
        default: rb = W'($urandom);
      endcase
      run_op(ra, rb, int'($urandom_range(0, 3)), "rand");
    end

    @(negedge clk);
    check("dup_results", 64'(dup_cnt), 64'd0);
    check("pending_results", 64'(pending), 64'd0);
    check("result_count", 64'(res_cnt), 64'(ops_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
